a2g_lut_dump_ctrl: RTL and testbench
====================================

// Module: a2g_lut_dump_ctrl
// PURPOSE
//  Sequences a read-out ("dump") of the a2g control LUT: on a start command it walks LUT
//  addresses 0..num_words-1 and streams the words out over a valid/ready interface.
//  Drives the sending_data status bit that software polls through the
//  lut_dump_sending_data simulink2ppc register.
//  Sits between the software-register controls and the LUT read port, in the user_clk domain.
// PARAMETERS
//  ADDR_W   10  LUT address width; max dump length is 2^ADDR_W words
//  DATA_W   32  LUT word width
//  RD_LAT   2   fixed LUT read latency in cycles, from lut_rd_en to lut_rdata valid (>=1)
// PORTS
//  user_clk      in   1         sole clock
//  user_rst_n    in   1         asynchronous, active-low reset
//  start         in   1         1-cycle pulse: begin dump (ignored unless IDLE)
//  abort         in   1         1-cycle pulse: cancel dump in progress
//  num_words     in   ADDR_W+1  dump length, sampled on accepted start
//  lut_rd_en     out  1         LUT read strobe
//  lut_addr      out  ADDR_W    LUT read address
//  lut_rdata     in   DATA_W    LUT read data, valid RD_LAT cycles after lut_rd_en
//  tx_data       out  DATA_W    streamed word
//  tx_valid      out  1         tx_data valid
//  tx_ready      in   1         downstream accepts when tx_valid&tx_ready
//  tx_last       out  1         marks final word of a dump
//  sending_data  out  1         high from accepted start until last word accepted, or abort
//  dump_done     out  1         1-cycle pulse after last word accepted
//  dump_aborted  out  1         1-cycle pulse when abort takes effect
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters/FIFO cleared; reset mid-dump discards all state.
//  FSM: IDLE -start-> READ (num_words latched, addr=0, sending_data=1 next cycle).
//       IDLE -start & num_words==0-> DONE (no reads; dump_done pulses, sending_data stays 0).
//       READ: issue read when credit available; after num_words reads issued -> DRAIN.
//       DRAIN: wait for in-flight reads and FIFO to empty and last word accepted -> DONE.
//       DONE: dump_done=1 for one cycle, sending_data=0 -> IDLE.
//       Any state except IDLE -abort-> IDLE; dump_aborted=1 for one cycle; FIFO flushed;
//       in-flight read returns are dropped (discard counter); sending_data=0 next cycle.
//       A start arriving in that same cycle, or in any non-IDLE cycle, is ignored.
//  Credit: outstanding_reads + fifo_count < FIFO_D (FIFO_D=RD_LAT+2) gates lut_rd_en.
//       This guarantees no FIFO overflow under arbitrary tx_ready backpressure.
//       With tx_ready held high, sustained throughput is 1 word/cycle.
//  Latency: start at cycle 0 -> lut_rd_en/addr 0 at cycle 1 -> first tx_valid at cycle 1+RD_LAT+1.
//  Address: lut_addr increments by 1 per issued read; num_words=2^ADDR_W covers the full LUT.
//       The address counter reaches all-ones, then the issue count terminates (no re-read of 0).
//  Stream: tx_valid/tx_data stay stable while tx_valid&!tx_ready. tx_last is asserted with the
//       num_words-th word only. Word count is tracked on accept (ADDR_W+1 bits).
//  Simultaneous: FIFO push & pop in the same cycle keeps the count. abort beats a last-word
//       accept in the same cycle (dump_aborted, no dump_done).
// STRUCTURE
//  Package a2g_dump_pkg: FSM state enum (IDLE,READ,DRAIN,DONE), FIFO_D localparam function.
//  Sub-module a2g_dump_skid_fifo: FIFO_D-deep, show-ahead, synchronous flush, count output.
//  Top level holds the FSM, address/issue counters, RD_LAT-deep valid shift register for
//  in-flight reads, and the discard counter.
// TESTING
//  1) num_words=8, tx_ready=1: addrs 0..7, one per cycle; 8 words; tx_last on word 7;
//     first tx_valid at cycle 4 (RD_LAT=2); dump_done 1 cycle; sending_data high for the dump.
//  2) num_words=1024 (full LUT), random tx_ready at 30%: all 1024 words in order,
//     no FIFO overflow, outstanding+count<=4 at all times.
//  3) num_words=0: no lut_rd_en; dump_done pulses; sending_data never rises.
//  4) abort at word 5 of 16 with reads in flight: dump_aborted pulse; no further tx_valid;
//     next start dumps addrs from 0 cleanly.
//  5) start pulsed during READ: ignored, dump unchanged; tx_ready=0 for 20 cycles:
//     rd_en stops after 4 reads, tx_data held stable.
//  6) user_rst_n low mid-dump: all outputs 0 asynchronously; after release, IDLE, accepts start.

Source files
------------

// File: rtl/a2g_dump_pkg.sv
// Shared types and sizing helpers for the a2g LUT dump controller.
package a2g_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } dump_state_e;

  // Two extra entries beyond the read pipeline keep issue running at 1 word/cycle.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/a2g_lut_dump_ctrl_if.sv
// Valid/ready stream carrying dumped LUT words to the downstream consumer.
interface a2g_lut_dump_ctrl_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/a2g_dump_skid_fifo.sv
// Show-ahead FIFO buffering LUT read returns against downstream backpressure.
module a2g_dump_skid_fifo
  import a2g_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign do_push    = push && (count != CNT_W'(DEPTH));
  assign do_pop     = pop && head_valid;

  // NOTE: storage has no reset; contents are only observed behind head_valid,
  // which comes from the reset count, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/a2g_lut_dump_ctrl.sv
// Walks LUT addresses 0..num_words-1 and streams the returned words out,
// with credit-based read issue so the skid FIFO never overflows.
module a2g_lut_dump_ctrl
  import a2g_dump_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_words,
  output logic              lut_rd_en,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_rdata,
  a2g_lut_dump_ctrl_if.master tx,
  output logic              sending_data,
  output logic              dump_done,
  output logic              dump_aborted
);

  localparam int FIFO_D = fifo_depth(RD_LAT);
  localparam int CNT_W  = cnt_width(FIFO_D);
  localparam int SUM_W  = CNT_W + 1;
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  dump_state_e       state, state_nxt;
  logic [ADDR_W:0]   num_q, issue_cnt, acc_cnt;
  logic [RD_LAT-1:0] vld_sr;
  logic [CNT_W-1:0]  fifo_count, in_flight;
  logic              credit, accept, last_issue, abort_hit, start_hit, aborted_q;

  assign in_flight  = CNT_W'($countones(vld_sr));
  assign credit     = ({1'b0, in_flight} + {1'b0, fifo_count}) < SUM_W'(FIFO_D);
  assign abort_hit  = abort && (state != IDLE);
  assign start_hit  = start && (state == IDLE);
  assign accept     = tx.tx_valid && tx.tx_ready;
  assign last_issue = (issue_cnt + ONE) == num_q;

  assign tx.tx_last   = tx.tx_valid && ((acc_cnt + ONE) == num_q);
  assign lut_addr     = issue_cnt[ADDR_W-1:0];
  assign sending_data = (state == READ) || (state == DRAIN);
  assign dump_done    = (state == DONE);
  assign dump_aborted = aborted_q;

  // NOTE: defaults come first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    lut_rd_en = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (num_words == '0) ? DONE : READ;
      READ: begin
        if (credit) begin
          lut_rd_en = 1'b1;
          if (last_issue) state_nxt = DRAIN;
        end
      end
      DRAIN: if (accept && tx.tx_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = IDLE;
      lut_rd_en = 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      num_q     <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
      if (start_hit) begin
        num_q     <= num_words;
        issue_cnt <= '0;
        acc_cnt   <= '0;
      end else begin
        if (lut_rd_en) issue_cnt <= issue_cnt + ONE;
        if (accept)    acc_cnt   <= acc_cnt + ONE;
      end
    end
  end

  // Clearing the in-flight markers on abort drops late read returns on the floor.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      vld_sr <= '0;
    end else if (abort_hit) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= lut_rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  a2g_dump_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .clk        (user_clk),
    .rst_n      (user_rst_n),
    .flush      (abort_hit),
    .push       (vld_sr[RD_LAT-1]),
    .push_data  (lut_rdata),
    .pop        (tx.tx_ready),
    .head_data  (tx.tx_data),
    .head_valid (tx.tx_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_a2g_lut_dump_ctrl.sv
// Directed-plus-random bench for a2g_lut_dump_ctrl; expected streams come from a LUT image.
module tb_a2g_lut_dump_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = RD_LAT + 2;
  localparam int LUT_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              lut_rd_en;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_rdata, lut_pipe;
  logic              sending_data, dump_done, dump_aborted;
  logic [DATA_W-1:0] lut_mem [LUT_N];

  a2g_lut_dump_ctrl_if #(.DATA_W(DATA_W)) tx_if ();

  a2g_lut_dump_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .user_clk     (clk),
    .user_rst_n   (rst_n),
    .start        (start),
    .abort        (abort),
    .num_words    (num_words),
    .lut_rd_en    (lut_rd_en),
    .lut_addr     (lut_addr),
    .lut_rdata    (lut_rdata),
    .tx           (tx_if),
    .sending_data (sending_data),
    .dump_done    (dump_done),
    .dump_aborted (dump_aborted)
  );

  always #5 clk = ~clk;

  // LUT with a fixed two-cycle read pipeline
  always @(posedge clk) begin
    lut_pipe  <= lut_mem[lut_addr];
    lut_rdata <= lut_pipe;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                rd_addr_q[$], rd_cyc_q[$], acc_cyc_q[$], done_cyc_q[$], abt_cyc_q[$];
  logic [DATA_W-1:0] acc_data_q[$];
  bit                acc_last_q[$];
  int                send_total = 0, stab_err = 0, last_vld_cyc = -1;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (lut_rd_en) begin
        rd_addr_q.push_back(int'(lut_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (tx_if.tx_valid) last_vld_cyc = cyc;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        acc_data_q.push_back(tx_if.tx_data);
        acc_last_q.push_back(tx_if.tx_last);
        acc_cyc_q.push_back(cyc);
      end
      if (dump_done)    done_cyc_q.push_back(cyc);
      if (dump_aborted) abt_cyc_q.push_back(cyc);
      if (sending_data) send_total++;
      if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data !== prev_data)) stab_err++;
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n, output int sc);
    num_words = (ADDR_W + 1)'(n);
    start     = 1'b1;
    sc        = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k = 0;
    while (done_cyc_q.size() == base && k < budget) begin
      tick();
      k++;
    end
    check(tag, done_cyc_q.size() > base, 1);
  endtask

  // Reference: a dump of n words reads addresses 0..n-1 and delivers lut_mem[0..n-1] in order.
  task automatic check_dump(input string tag, input int n, input int rd_base, input int acc_base);
    int bad_addr = 0, bad_data = 0, lasts = 0;
    for (int i = 0; i < n; i++) begin
      if (rd_base + i >= rd_addr_q.size() || rd_addr_q[rd_base + i] != i) bad_addr++;
      if (acc_base + i >= acc_data_q.size() || acc_data_q[acc_base + i] !== lut_mem[i]) bad_data++;
    end
    for (int i = acc_base; i < acc_last_q.size(); i++) if (acc_last_q[i]) lasts++;
    check({tag, "_num_reads"}, rd_addr_q.size() - rd_base, n);
    check({tag, "_num_words"}, acc_data_q.size() - acc_base, n);
    check({tag, "_addr_errs"}, bad_addr, 0);
    check({tag, "_data_errs"}, bad_data, 0);
    check({tag, "_last_count"}, lasts, 1);
    if (acc_base + n - 1 < acc_last_q.size())
      check({tag, "_last_on_final"}, acc_last_q[acc_base + n - 1], 1);
    else
      check({tag, "_last_on_final"}, 0, 1);
  endtask

  initial begin
    int sc, ac, rb, ab, db, tb0, st0, sb0, k, out, max_out, n;
    int bad;
    for (int i = 0; i < LUT_N; i++) lut_mem[i] = $urandom();
    tx_if.tx_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", lut_rd_en, 0);
    check("rst_addr", lut_addr, 0);
    check("rst_tx_valid", tx_if.tx_valid, 0);
    check("rst_tx_last", tx_if.tx_last, 0);
    check("rst_tx_data", tx_if.tx_data, 0);
    check("rst_sending", sending_data, 0);
    check("rst_done", dump_done, 0);
    check("rst_aborted", dump_aborted, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // 8-word dump, no backpressure: latency and throughput
    tx_if.tx_ready = 1'b1;
    rb = rd_addr_q.size(); ab = acc_data_q.size(); db = done_cyc_q.size(); st0 = send_total;
    pulse_start(8, sc);
    wait_done(db, 200, "t1_done_seen");
    repeat (3) tick();
    check_dump("t1", 8, rb, ab);
    check("t1_first_rd_cyc", rd_cyc_q[rb], sc + 1);
    check("t1_rd_b2b", rd_cyc_q[rb + 7] - rd_cyc_q[rb], 7);
    check("t1_first_valid_cyc", acc_cyc_q[ab], sc + 1 + RD_LAT + 1);
    check("t1_word_per_cycle", acc_cyc_q[ab + 7] - acc_cyc_q[ab], 7);
    check("t1_done_count", done_cyc_q.size() - db, 1);
    check("t1_done_cyc", done_cyc_q[db], acc_cyc_q[ab + 7] + 1);
    check("t1_sending_cycles", send_total - st0, acc_cyc_q[ab + 7] - sc);
    check("t1_idle_valid", tx_if.tx_valid, 0);

    // Zero-length dump
    rb = rd_addr_q.size(); db = done_cyc_q.size(); st0 = send_total;
    pulse_start(0, sc);
    repeat (6) tick();
    check("t3_no_reads", rd_addr_q.size() - rb, 0);
    check("t3_done_count", done_cyc_q.size() - db, 1);
    check("t3_done_cyc", done_cyc_q[db], sc + 1);
    check("t3_sending_never", send_total - st0, 0);

    // Full LUT with random 30% ready
    rb = rd_addr_q.size(); ab = acc_data_q.size(); db = done_cyc_q.size(); sb0 = stab_err;
    max_out = 0;
    pulse_start(LUT_N, sc);
    k = 0;
    while (done_cyc_q.size() == db && k < 20000) begin
      tx_if.tx_ready = ($urandom_range(0, 9) < 3);
      tick();
      k++;
      out = (rd_addr_q.size() - rb) - (acc_data_q.size() - ab);
      if (out > max_out) max_out = out;
    end
    tx_if.tx_ready = 1'b1;
    check("t2_done_seen", done_cyc_q.size() > db, 1);
    tick();
    check_dump("t2", LUT_N, rb, ab);
    check("t2_outstanding_bound", max_out <= FIFO_D, 1);
    check("t2_stall_stability", stab_err - sb0, 0);

    // Abort at word 5 of 16 with reads in flight
    rb = rd_addr_q.size(); ab = acc_data_q.size(); db = done_cyc_q.size(); tb0 = abt_cyc_q.size();
    pulse_start(16, sc);
    k = 0;
    while (acc_data_q.size() - ab < 5 && k < 100) begin
      tick();
      k++;
    end
    abort = 1'b1;
    ac = cyc;
    tick();
    abort = 1'b0;
    repeat (10) tick();
    n = acc_data_q.size() - ab;
    bad = 0;
    for (int i = 0; i < n; i++) if (acc_data_q[ab + i] !== lut_mem[i]) bad++;
    check("t4_reads_in_flight", (rd_addr_q.size() - rb) > n, 1);
    check("t4_aborted_count", abt_cyc_q.size() - tb0, 1);
    check("t4_aborted_cyc", abt_cyc_q[tb0], ac + 1);
    check("t4_no_done", done_cyc_q.size() - db, 0);
    check("t4_no_valid_after", last_vld_cyc <= ac, 1);
    check("t4_words_before_abort", (n == 5) || (n == 6), 1);
    check("t4_prefix_data", bad, 0);
    check("t4_sending_low", sending_data, 0);
    rb = rd_addr_q.size(); ab = acc_data_q.size(); db = done_cyc_q.size();
    pulse_start(4, sc);
    wait_done(db, 100, "t4_restart_done");
    tick();
    check_dump("t4_restart", 4, rb, ab);

    // Start during READ ignored; 20 cycles of backpressure
    tx_if.tx_ready = 1'b0;
    rb = rd_addr_q.size(); ab = acc_data_q.size(); db = done_cyc_q.size(); sb0 = stab_err;
    pulse_start(32, sc);
    tick();
    num_words = (ADDR_W + 1)'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    check("t5_reads_stalled", rd_addr_q.size() - rb, FIFO_D);
    check("t5_no_accept", acc_data_q.size() - ab, 0);
    check("t5_valid_held", tx_if.tx_valid, 1);
    check("t5_data_held", tx_if.tx_data, lut_mem[0]);
    check("t5_stall_stability", stab_err - sb0, 0);
    tx_if.tx_ready = 1'b1;
    wait_done(db, 200, "t5_done_seen");
    tick();
    check_dump("t5", 32, rb, ab);
    check("t5_done_count", done_cyc_q.size() - db, 1);

    // Asynchronous reset mid-dump
    pulse_start(64, sc);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_sending", sending_data, 0);
    check("t6_rst_tx_valid", tx_if.tx_valid, 0);
    check("t6_rst_rd_en", lut_rd_en, 0);
    check("t6_rst_addr", lut_addr, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_idle_sending", sending_data, 0);
    rb = rd_addr_q.size(); ab = acc_data_q.size(); db = done_cyc_q.size();
    pulse_start(3, sc);
    wait_done(db, 100, "t6_done_seen");
    tick();
    check_dump("t6", 3, rb, ab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
